pll_fll_ctrl: RTL and testbench
===============================

# pll_fll_ctrl

- Parametrised all-digital frequency-locked-loop controller for the MSSF PLL macro.
- Measures the divided oscillator feedback clock against a window of system clocks and steers a DCO trim code toward a programmable target count.
- Flags lock after a configurable number of in-tolerance windows.
- Sits between the Tiny Tapeout digital pins and the analog oscillator trim inputs.

## Interface

Parameters:
- CNT_W, 12: width of edge counter, target and measurement.
- CODE_W, 6: DCO trim code width; a higher code gives a higher frequency.
- WINDOW, 256: clk cycles per measurement window; range 2..2^16.
- LOCK_TOL, 2: allowed absolute error |target − meas|, in edges.
- LOCK_N, 4: consecutive in-tolerance windows required to assert lock; range 1..15.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- en  in  1  loop enable.
- fb_in  in  1  feedback clock from the oscillator divider; asynchronous to clk.
- target  in  CNT_W  desired rising edges per window; sampled at each window start.
- dco_code  out  CODE_W  trim code driven to the oscillator.
- meas  out  CNT_W  last completed window's edge count.
- meas_valid  out  1  one-cycle pulse when meas updates.
- locked  out  1  lock indicator.
- sat  out  1  high while tracking wants to step dco_code beyond 0 or 2^CODE_W−1.

## Operation

- **Feedback input path:** fb_in goes through a 2-FF synchronizer, then a rising-edge detector. The edge counter saturates at 2^CNT_W−1.
- **FSM states:**
  - IDLE: counters cleared.
  - MEAS: window counter runs 0..WINDOW−1 and detected edges are counted.
  - UPD: single cycle.
- **Transitions:**
  - IDLE→MEAS when en=1.
  - MEAS→UPD on the last window cycle.
  - UPD→MEAS unconditionally.
  - Any state→IDLE when en=0.
- **Edge counting:**
  - An edge detected on the last MEAS cycle is counted in the closing window.
  - Edges detected during UPD are discarded.
- **Entering UPD:** meas gets the count and meas_valid pulses.
- **Error calculation:** err = target_latched − meas, computed signed at CNT_W+1 bits; no overflow is possible.
- **Tracking update, applied in UPD:**
  - |err| ≤ LOCK_TOL: code held; lock_cnt increments, saturating at LOCK_N.
  - err > LOCK_TOL: code +1.
  - err < −LOCK_TOL: code −1.
  - In both out-of-tolerance cases, lock_cnt is cleared.
- **Code limits:**
  - The code saturates at 0 and 2^CODE_W−1.
  - sat=1 when a step is blocked by a limit; sat clears on the next unblocked UPD.
- **Lock:**
  - locked=1 when lock_cnt reaches LOCK_N.
  - locked clears in the same UPD as the first out-of-tolerance window.
- **en=0:**
  - Next cycle: IDLE, counters and lock_cnt cleared, locked=0, meas_valid=0.
  - dco_code and meas are held.
  - A partial window produces no meas_valid.
  - Re-enable starts a fresh window.
- **rst mid-operation:** overrides everything, including en.

## Timing

- Reset values:
  - dco_code = 2^(CODE_W−1).
  - meas = 0, meas_valid = 0, locked = 0, sat = 0.
  - FSM in IDLE.
- fb_in to counted edge: 3 clk cycles (2 synchronizer stages plus the detector).
- Window period: WINDOW+1 clk cycles (WINDOW MEAS cycles plus 1 UPD cycle).
- meas_valid, dco_code, locked and sat all update on the clock edge leaving UPD; all are registered.
- Maximum countable fb frequency is clk/2. Faster input aliases, and this is not a supported use.

## Configuration

- **PLL_FLL_BINSEARCH_EN defined:**
  - After reset and after each en rising edge, the controller runs a successive-approximation search for CODE_W windows.
  - The search starts at code 2^(CODE_W−1) with bit index b=CODE_W−1.
  - In each UPD: if meas > target, clear bit b; then set bit b−1 when b>0, and decrement b.
  - After bit 0 is decided, the controller enters tracking.
  - During the search, lock_cnt is held at 0, locked=0 and sat=0.
- **Macro undefined:** tracking only, starting from the current dco_code; no search logic is synthesised.

## Test plan

Parameters for all scenarios: CNT_W=12, CODE_W=6, WINDOW=256, LOCK_TOL=2, LOCK_N=4. The oscillator model gives edges per window = 2×dco_code.

- **Reset:**
  - Stimulus: assert rst for 2 cycles with en=1.
  - Response: dco_code=32, meas=0, locked=0, sat=0, no meas_valid.
- **Linear tracking (macro off):**
  - Stimulus: target=80.
  - Response: code steps 32→39 over 7 windows and holds at 39 (meas=78, err=2). locked rises at the UPD of the 11th window.
- **Saturation:**
  - Stimulus: target=4000.
  - Response: code climbs to 63 after 31 windows, then sat=1, locked=0, and code holds at 63.
- **Lock loss:**
  - Stimulus: after lock, switch the model to edges=dco_code.
  - Response: next meas=39, locked falls in that UPD, code steps to 40.
- **en drop mid-window:**
  - Stimulus: en=0 at window cycle 100.
  - Response: no meas_valid, dco_code held, locked=0. After en=1, the next meas_valid comes 257 cycles later (plus synchronizer latency for edges).
- **Binary search (macro on):**
  - Stimulus: target=80.
  - Response: code sequence 32, 48, 40, 44, 42, 41, ending at 40 after 6 windows. The next window gives meas=80, and locked is set after 4 tracking windows.

Source files
------------

// File: rtl/pll_fll_ctrl.sv
// pll_fll_ctrl -- all-digital frequency-locked-loop controller for the MSSF
// PLL macro. Counts rising edges of the divided oscillator feedback over a
// window of WINDOW system clocks. After each window it steps the DCO trim
// code one LSB toward the programmable target count. Lock is flagged after
// LOCK_N consecutive windows within LOCK_TOL edges of the target.
//
// Optional feature: define PLL_FLL_BINSEARCH_EN to run a CODE_W-window
// successive-approximation search after reset and after every enable, before
// tracking starts.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   en         loop enable; low returns the FSM to idle
//   fb_in      divided oscillator feedback, asynchronous to clk
//   target     desired rising edges per window, sampled at window start
//   dco_code   trim code to the oscillator (higher code = higher frequency)
//   meas       edge count of the last completed window
//   meas_valid one-cycle pulse when meas updates
//   locked     lock indicator
//   sat        a tracking step was blocked by a code limit
module pll_fll_ctrl #(
  parameter int CNT_W    = 12,
  parameter int CODE_W   = 6,
  parameter int WINDOW   = 256,
  parameter int LOCK_TOL = 2,
  parameter int LOCK_N   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              fb_in,
  input  logic [CNT_W-1:0]  target,
  output logic [CODE_W-1:0] dco_code,
  output logic [CNT_W-1:0]  meas,
  output logic              meas_valid,
  output logic              locked,
  output logic              sat
);

  localparam int                 WIN_W    = $clog2(WINDOW);
  localparam int                 ERR_W    = CNT_W + 1;
  localparam logic [WIN_W-1:0]   WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [CODE_W-1:0]  CODE_MID = {1'b1, {(CODE_W-1){1'b0}}};
  localparam logic [3:0]         LOCK_MAX = 4'(LOCK_N);
  localparam logic [3:0]         LOCK_PRE = 4'(LOCK_N - 1);
  localparam logic signed [CNT_W:0] TOL_P = ERR_W'(LOCK_TOL);
  localparam logic signed [CNT_W:0] TOL_N = -TOL_P;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MEAS = 2'd1;
  localparam logic [1:0] S_UPD  = 2'd2;

  logic [1:0]            state;
  logic [WIN_W-1:0]      win_cnt;
  logic [CNT_W-1:0]      edge_cnt;
  logic [CNT_W-1:0]      edge_cnt_nx;
  logic [CNT_W-1:0]      target_l;
  logic [3:0]            lock_cnt;
  logic                  fb_s1, fb_s2, fb_s3;
  logic                  fb_rise;
  logic                  win_last;
  logic signed [CNT_W:0] err;

  // Two synchronizer stages plus one history flop for the edge detector.
  always_ff @(posedge clk) begin
    if (rst) begin
      fb_s1 <= 1'b0;
      fb_s2 <= 1'b0;
      fb_s3 <= 1'b0;
    end else begin
      fb_s1 <= fb_in;
      fb_s2 <= fb_s1;
      fb_s3 <= fb_s2;
    end
  end

  assign fb_rise  = fb_s2 & ~fb_s3;
  assign win_last = (win_cnt == WIN_LAST);

  always_comb begin
    edge_cnt_nx = edge_cnt;
    if (fb_rise && (edge_cnt != '1))
      edge_cnt_nx = edge_cnt + 1'b1;
  end

  // Zero-extended operands: the CNT_W+1 bit difference cannot overflow.
  assign err = $signed({1'b0, target_l}) - $signed({1'b0, edge_cnt});

`ifdef PLL_FLL_BINSEARCH_EN
  localparam int               BIT_W   = (CODE_W > 1) ? $clog2(CODE_W) : 1;
  localparam logic [BIT_W-1:0] BIT_TOP = BIT_W'(CODE_W - 1);

  logic              srch;
  logic [BIT_W-1:0]  bit_idx;
  logic [CODE_W-1:0] srch_code;

  // Decide bit_idx from the closing window, then trial-set the next bit down.
  always_comb begin
    srch_code = dco_code;
    if (edge_cnt > target_l)
      srch_code[bit_idx] = 1'b0;
    if (bit_idx != '0)
      srch_code[bit_idx - 1'b1] = 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      win_cnt    <= '0;
      edge_cnt   <= '0;
      target_l   <= '0;
      lock_cnt   <= '0;
      dco_code   <= CODE_MID;
      meas       <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      sat        <= 1'b0;
`ifdef PLL_FLL_BINSEARCH_EN
      srch       <= 1'b1;
      bit_idx    <= BIT_TOP;
`endif
    end else begin
      meas_valid <= 1'b0;
      if (!en) begin
        state    <= S_IDLE;
        win_cnt  <= '0;
        edge_cnt <= '0;
        lock_cnt <= '0;
        locked   <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            state    <= S_MEAS;
            win_cnt  <= '0;
            edge_cnt <= '0;
            target_l <= target;
`ifdef PLL_FLL_BINSEARCH_EN
            // Leaving idle is always an enable rising edge: restart the search.
            srch     <= 1'b1;
            bit_idx  <= BIT_TOP;
            dco_code <= CODE_MID;
            sat      <= 1'b0;
            lock_cnt <= '0;
            locked   <= 1'b0;
`endif
          end
          S_MEAS: begin
            edge_cnt <= edge_cnt_nx;
            if (win_last) begin
              state   <= S_UPD;
              win_cnt <= '0;
            end else begin
              win_cnt <= win_cnt + 1'b1;
            end
          end
          S_UPD: begin
            // Edges seen in this cycle are dropped; the next window starts clean.
            state      <= S_MEAS;
            win_cnt    <= '0;
            edge_cnt   <= '0;
            target_l   <= target;
            meas       <= edge_cnt;
            meas_valid <= 1'b1;
`ifdef PLL_FLL_BINSEARCH_EN
            if (srch) begin
              dco_code <= srch_code;
              lock_cnt <= '0;
              locked   <= 1'b0;
              sat      <= 1'b0;
              if (bit_idx == '0)
                srch <= 1'b0;
              else
                bit_idx <= bit_idx - 1'b1;
            end else
`endif
            begin
              if (err > TOL_P) begin
                lock_cnt <= '0;
                locked   <= 1'b0;
                if (dco_code == '1) begin
                  sat <= 1'b1;
                end else begin
                  dco_code <= dco_code + 1'b1;
                  sat      <= 1'b0;
                end
              end else if (err < TOL_N) begin
                lock_cnt <= '0;
                locked   <= 1'b0;
                if (dco_code == '0) begin
                  sat <= 1'b1;
                end else begin
                  dco_code <= dco_code - 1'b1;
                  sat      <= 1'b0;
                end
              end else begin
                sat <= 1'b0;
                if (lock_cnt != LOCK_MAX)
                  lock_cnt <= lock_cnt + 1'b1;
                locked <= (lock_cnt >= LOCK_PRE);
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pll_fll_ctrl.sv
// Testbench for pll_fll_ctrl. A behavioural oscillator places an exact number
// of feedback pulses inside each measurement window. A window-level reference
// model predicts meas, dco_code, locked and sat after every window.
module tb_pll_fll_ctrl;
  localparam int CNT_W    = 12;
  localparam int CODE_W   = 6;
  localparam int WINDOW   = 256;
  localparam int LOCK_TOL = 2;
  localparam int LOCK_N   = 4;
  localparam int CODE_MAX = (1 << CODE_W) - 1;
  localparam int CODE_RST = 1 << (CODE_W - 1);

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              en = 1'b0;
  logic              fb_in = 1'b0;
  logic [CNT_W-1:0]  target = '0;
  logic [CODE_W-1:0] dco_code;
  logic [CNT_W-1:0]  meas;
  logic              meas_valid;
  logic              locked;
  logic              sat;

  always #5 clk = ~clk;

  pll_fll_ctrl #(
    .CNT_W   (CNT_W),
    .CODE_W  (CODE_W),
    .WINDOW  (WINDOW),
    .LOCK_TOL(LOCK_TOL),
    .LOCK_N  (LOCK_N)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .fb_in     (fb_in),
    .target    (target),
    .dco_code  (dco_code),
    .meas      (meas),
    .meas_valid(meas_valid),
    .locked    (locked),
    .sat       (sat)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Reference model: state after each completed window.
  int m_code, m_meas, m_lock, m_bit;
  bit m_locked, m_sat, m_srch;

  // Oscillator: 0 -> 2*code edges, 1 -> code edges, 2 -> fixed_edges.
  int plant_mode  = 0;
  int fixed_edges = 0;

  bit pend = 1'b0;
  int p_t, p_e;

  function automatic void model_reset();
    m_code = CODE_RST; m_meas = 0; m_lock = 0;
    m_locked = 1'b0; m_sat = 1'b0; m_srch = 1'b0; m_bit = 0;
  endfunction

  function automatic void model_enable();
`ifdef PLL_FLL_BINSEARCH_EN
    m_srch = 1'b1; m_bit = CODE_W - 1; m_code = CODE_RST;
    m_sat = 1'b0; m_lock = 0; m_locked = 1'b0;
`endif
  endfunction

  function automatic void model_window(input int t, input int e);
    int err;
    m_meas = e;
    if (m_srch) begin
      if (e > t) m_code = m_code & ~(1 << m_bit);
      if (m_bit > 0) m_code = m_code | (1 << (m_bit - 1));
      else m_srch = 1'b0;
      m_bit--;
      m_lock = 0; m_locked = 1'b0; m_sat = 1'b0;
    end else begin
      err = t - e;
      if (err > LOCK_TOL) begin
        m_lock = 0;
        if (m_code == CODE_MAX) m_sat = 1'b1;
        else begin m_code++; m_sat = 1'b0; end
      end else if (err < -LOCK_TOL) begin
        m_lock = 0;
        if (m_code == 0) m_sat = 1'b1;
        else begin m_code--; m_sat = 1'b0; end
      end else begin
        m_sat = 1'b0;
        if (m_lock < LOCK_N) m_lock++;
      end
      m_locked = (m_lock >= LOCK_N);
    end
  endfunction

  function automatic int plant_edges();
    case (plant_mode)
      0:       return 2 * int'(dco_code);
      1:       return int'(dco_code);
      default: return fixed_edges;
    endcase
  endfunction

  // One window of WINDOW+1 cycles starting at the negedge before the window's
  // first posedge. The previous window's results are checked at c==1. A cut
  // value >= 2 drops en at that cycle and abandons the window.
  task automatic run_window(input int t, input int cut);
    int  n = 0;
    int  s = 2;
    bit  aborted = 1'b0;
    for (int c = 0; c <= WINDOW; c++) begin
      @(negedge clk);
      if (c == cut) begin
        en = 1'b0; fb_in = 1'b0; pend = 1'b0; aborted = 1'b1;
        break;
      end
      if (c == 0) begin
        check("mv_low", 32'(meas_valid), 32'd0);
        if (!en) begin model_enable(); en = 1'b1; end
        target = CNT_W'(t);
      end
      if (c == 1) begin
        if (pend) begin
          model_window(p_t, p_e);
          check("mv_pulse", 32'(meas_valid), 32'd1);
          check("meas",     32'(meas),       32'(m_meas));
          check("code",     32'(dco_code),   32'(m_code));
          check("locked",   32'(locked),     32'(m_locked));
          check("sat",      32'(sat),        32'(m_sat));
        end
        n = plant_edges();
        s = $urandom_range(WINDOW - 2 * n, 2);
      end
      if (c >= 2) fb_in = (c >= s) && (c < s + 2 * n) && (((c - s) % 2) == 0);
    end
    if (!aborted) begin pend = 1'b1; p_t = t; p_e = n; end
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b1; fb_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_code",   32'(dco_code),   32'(CODE_RST));
    check("rst_meas",   32'(meas),       32'd0);
    check("rst_mv",     32'(meas_valid), 32'd0);
    check("rst_locked", 32'(locked),     32'd0);
    check("rst_sat",    32'(sat),        32'd0);
    rst = 1'b0; en = 1'b0; pend = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  task automatic drop_en(input int t, input int cut, input int idle);
    int pulses = 0;
    run_window(t, cut);
    m_lock = 0; m_locked = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("drop_locked", 32'(locked),   32'd0);
    check("drop_code",   32'(dco_code), 32'(m_code));
    check("drop_meas",   32'(meas),     32'(m_meas));
    for (int i = 0; i < idle; i++) begin
      @(negedge clk);
      if (meas_valid) pulses++;
    end
    check("drop_no_mv", 32'(pulses), 32'd0);
    check("drop_hold",  32'(dco_code), 32'(m_code));
  endtask

  initial begin
    model_reset();
    do_reset();

    // Linear tracking toward 80 edges with a 2*code oscillator.
    plant_mode = 0;
    for (int w = 0; w < 14; w++) run_window(80, -1);
`ifdef PLL_FLL_BINSEARCH_EN
    check("track_code", 32'(dco_code), 32'd40);
`else
    check("track_code", 32'(dco_code), 32'd39);
`endif
    check("track_locked", 32'(locked), 32'd1);

    // Oscillator gain halves: lock is lost in the very next update.
    plant_mode = 1;
    for (int w = 0; w < 2; w++) run_window(80, -1);
`ifdef PLL_FLL_BINSEARCH_EN
    check("loss_meas", 32'(meas), 32'd40);
    check("loss_code", 32'(dco_code), 32'd41);
`else
    check("loss_meas", 32'(meas), 32'd39);
    check("loss_code", 32'(dco_code), 32'd40);
`endif
    check("loss_locked", 32'(locked), 32'd0);

    // Relock, then drop en part-way through a window.
    plant_mode = 0;
    for (int w = 0; w < 6; w++) run_window(80, -1);
    drop_en(80, 100, 300);
    for (int w = 0; w < 3; w++) run_window(80, -1);

    // Upper code limit.
    for (int w = 0; w < 40; w++) run_window(4000, -1);
    check("satu_code",   32'(dco_code), 32'(CODE_MAX));
    check("satu_sat",    32'(sat),      32'd1);
    check("satu_locked", 32'(locked),   32'd0);

    // Lower code limit.
    plant_mode = 2; fixed_edges = 100;
    for (int w = 0; w < 68; w++) run_window(0, -1);
    check("satl_code", 32'(dco_code), 32'd0);
    check("satl_sat",  32'(sat),      32'd1);

    // Randomized targets, oscillator behaviour, en drops and resets.
    for (int w = 0; w < 50; w++) begin
      int r, t;
      r = $urandom_range(19, 0);
      t = ($urandom_range(7, 0) == 0) ? $urandom_range(4095, 0) : $urandom_range(160, 0);
      plant_mode  = $urandom_range(2, 0);
      fixed_edges = $urandom_range(126, 0);
      if (r == 0) drop_en(t, $urandom_range(250, 2), 20);
      else if (r == 1) do_reset();
      else run_window(t, -1);
    end
    run_window(0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
